// File: rtl/petris_pkg.sv
// Shared definitions for the tetrimino engine and its front end.
// Op-code constants are the contract between move_scheduler and the engine;
// the scheduler state enum is used only by move_scheduler.
package petris_pkg;

  localparam logic [2:0] OP_NONE   = 3'd0;
  localparam logic [2:0] OP_LEFT   = 3'd1;
  localparam logic [2:0] OP_RIGHT  = 3'd2;
  localparam logic [2:0] OP_ROTATE = 3'd3;
  localparam logic [2:0] OP_START  = 3'd4;
  localparam logic [2:0] OP_FALL   = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    ISSUE = 2'd2,
    OVER  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/gravity_timer.sv
// Gravity frame counter plus score-driven level / period computation.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   frame_tick      : one-cycle pulse per frame
//   run             : counter advances on frame_tick only while high
//   clear           : forces the counter back to 0 (new game)
//   score           : cleared-row count
//   level           : registered min(score / LINES_PER_LEVEL, 15)
//   gravity_period  : registered max(BASE - level*STEP, MIN)
//   fall_pulse      : combinational, high on the tick that wraps the counter
module gravity_timer
  import petris_pkg::*;
#(
  parameter int GRAVITY_BASE    = 48,
  parameter int GRAVITY_MIN     = 6,
  parameter int LEVEL_STEP      = 4,
  parameter int LINES_PER_LEVEL = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       run,
  input  logic       clear,
  input  logic [7:0] score,
  output logic [3:0] level,
  output logic [5:0] gravity_period,
  output logic       fall_pulse
);

  logic        [5:0] cnt_q, cnt_d;
  logic        [3:0] level_q, level_d;
  logic        [5:0] period_q, period_d;
  logic        [7:0] quot;
  logic signed [9:0] base_s, step_s, lvl_s, min_s, diff_s;
  logic              wrap;

  always_comb begin
    quot    = 8'(32'(score) / 32'(LINES_PER_LEVEL));
    level_d = (quot > 8'd15) ? 4'd15 : quot[3:0];

    // Signed 10-bit arithmetic so a high level cannot underflow the period.
    base_s = 10'(GRAVITY_BASE);
    step_s = 10'(LEVEL_STEP);
    min_s  = 10'(GRAVITY_MIN);
    lvl_s  = signed'({6'd0, level_d});
    diff_s = base_s - lvl_s * step_s;
    period_d = (diff_s < min_s) ? 6'(GRAVITY_MIN) : diff_s[5:0];

    // >= rather than == so a period that shrinks below the running count
    // still wraps on the next tick instead of counting through 63.
    wrap = frame_tick && run && (cnt_q >= period_q - 6'd1);

    cnt_d = cnt_q;
    if (clear)                   cnt_d = 6'd0;
    else if (frame_tick && run)  cnt_d = wrap ? 6'd0 : cnt_q + 6'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= 6'd0;
      level_q  <= 4'd0;
      period_q <= 6'(GRAVITY_BASE);
    end else begin
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      period_q <= period_d;
    end
  end

  assign level          = level_q;
  assign gravity_period = period_q;
  assign fall_pulse     = wrap;

endmodule

// File: rtl/move_scheduler.sv
// Front end of the tetrimino engine: turns button levels and frame ticks
// into a single valid/ready stream of 3-bit engine operations.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   frame_tick                  : one pulse per vsync
//   btn_left/right/rotate/drop/start : synchronized button levels
//   engine_busy                 : suppresses arbitration while high
//   game_over                   : level from the engine
//   score                       : cleared-row count
//   op, op_valid, op_ready      : operation handshake to the engine
//   level, gravity_period       : registered difficulty outputs
module move_scheduler
  import petris_pkg::*;
#(
  parameter int GRAVITY_BASE    = 48,
  parameter int GRAVITY_MIN     = 6,
  parameter int LEVEL_STEP      = 4,
  parameter int LINES_PER_LEVEL = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_rotate,
  input  logic       btn_drop,
  input  logic       btn_start,
  input  logic       engine_busy,
  input  logic       game_over,
  input  logic [7:0] score,
  output logic [2:0] op,
  output logic       op_valid,
  input  logic       op_ready,
  output logic [3:0] level,
  output logic [5:0] gravity_period
);

  sched_state_e state_q, state_d;
  logic [2:0]   op_q, op_d;
  logic         op_valid_q, op_valid_d;
  // {start, rotate, right, left}; drop is level-sensitive and needs no edge.
  logic [3:0]   btn_prev_q, btn_prev_d, btn_now, press;
  logic         fl_left_q, fl_right_q, fl_rot_q, fl_fall_q;
  logic         fl_left_d, fl_right_d, fl_rot_d, fl_fall_d;
  logic         playing, xfer, lr_clash, fall_pulse, grav_clear;

  gravity_timer #(
    .GRAVITY_BASE   (GRAVITY_BASE),
    .GRAVITY_MIN    (GRAVITY_MIN),
    .LEVEL_STEP     (LEVEL_STEP),
    .LINES_PER_LEVEL(LINES_PER_LEVEL)
  ) u_gravity (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .run           (playing),
    .clear         (grav_clear),
    .score         (score),
    .level         (level),
    .gravity_period(gravity_period),
    .fall_pulse    (fall_pulse)
  );

  always_comb begin
    btn_now    = {btn_start, btn_rotate, btn_right, btn_left};
    press      = btn_now & ~btn_prev_q;
    btn_prev_d = btn_now;
    lr_clash   = press[0] & press[1];
    xfer       = op_valid_q && op_ready;
    // ISSUE carrying OP_START still belongs to the idle game, so it does not
    // count as play for gravity or flag purposes.
    playing    = (state_q == PLAY) || (state_q == ISSUE && op_q != OP_START);
    grav_clear = xfer && (op_q == OP_START);

    fl_left_d  = fl_left_q;
    fl_right_d = fl_right_q;
    fl_rot_d   = fl_rot_q;
    fl_fall_d  = fl_fall_q;

    // Clear the transferred flag first so a same-cycle set overrides it.
    if (xfer) begin
      case (op_q)
        OP_LEFT:   fl_left_d  = 1'b0;
        OP_RIGHT:  fl_right_d = 1'b0;
        OP_ROTATE: fl_rot_d   = 1'b0;
        OP_FALL:   fl_fall_d  = 1'b0;
        default:   ;
      endcase
    end

    if (playing) begin
      if (press[0] && !lr_clash) fl_left_d  = 1'b1;
      if (press[1] && !lr_clash) fl_right_d = 1'b1;
      if (press[2])              fl_rot_d   = 1'b1;
      if (fall_pulse || (btn_drop && frame_tick)) fl_fall_d = 1'b1;
    end

    if (state_q == IDLE || state_q == OVER) begin
      fl_left_d  = 1'b0;
      fl_right_d = 1'b0;
      fl_rot_d   = 1'b0;
      fl_fall_d  = 1'b0;
    end

    state_d    = state_q;
    op_d       = op_q;
    op_valid_d = op_valid_q;
    case (state_q)
      IDLE: begin
        if (press[3]) begin
          op_d       = OP_START;
          op_valid_d = 1'b1;
          state_d    = ISSUE;
        end
      end
      PLAY: begin
        if (game_over) begin
          state_d = OVER;
        end else if (!engine_busy &&
                     (fl_fall_q || fl_rot_q || fl_left_q || fl_right_q)) begin
          if (fl_fall_q)     op_d = OP_FALL;
          else if (fl_rot_q) op_d = OP_ROTATE;
          else if (fl_left_q) op_d = OP_LEFT;
          else               op_d = OP_RIGHT;
          op_valid_d = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (xfer) begin
          op_valid_d = 1'b0;
          state_d    = game_over ? OVER : PLAY;
        end
      end
      OVER: begin
        if (!game_over) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= OP_NONE;
      op_valid_q <= 1'b0;
      btn_prev_q <= 4'b1111;
      fl_left_q  <= 1'b0;
      fl_right_q <= 1'b0;
      fl_rot_q   <= 1'b0;
      fl_fall_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      op_valid_q <= op_valid_d;
      btn_prev_q <= btn_prev_d;
      fl_left_q  <= fl_left_d;
      fl_right_q <= fl_right_d;
      fl_rot_q   <= fl_rot_d;
      fl_fall_q  <= fl_fall_d;
    end
  end

  assign op       = op_q;
  assign op_valid = op_valid_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Scoreboard bench for move_scheduler: directed stimulus pushes expected ops,
// a negedge monitor pops and compares on every transfer.
module tb_move_scheduler;

  logic       clk = 1'b0;
  logic       reset, frame_tick;
  logic       btn_left, btn_right, btn_rotate, btn_drop, btn_start;
  logic       engine_busy, game_over, op_ready, op_valid;
  logic [7:0] score;
  logic [2:0] op;
  logic [3:0] level;
  logic [5:0] gravity_period;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [2:0] exp_q[$];

  move_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .btn_rotate    (btn_rotate),
    .btn_drop      (btn_drop),
    .btn_start     (btn_start),
    .engine_busy   (engine_busy),
    .game_over     (game_over),
    .score         (score),
    .op            (op),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .level         (level),
    .gravity_period(gravity_period)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare transfers against the scoreboard and verify op holds
  // steady while the engine applies backpressure.
  logic       hold_active = 1'b0;
  logic [2:0] hold_op     = 3'd0;
  always @(negedge clk) begin
    if (hold_active && op_valid) check("op_stable", int'(op), int'(hold_op));
    if (op_valid && op_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_op", int'(op), 0);
        if (op == 3'd0) check("unexpected_op_valid", 1, 0);
      end else begin
        check("op_transfer", int'(op), int'(exp_q.pop_front()));
      end
    end
    hold_active = op_valid && !op_ready;
    hold_op     = op;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    cyc(1);
  endtask

  task automatic start_game();
    exp_q.push_back(3'd4);
    btn_start = 1'b1;
    cyc(1);
    btn_start = 1'b0;
    cyc(3);
  endtask

  task automatic chk_score(input int s, input int lv, input int per);
    score = 8'(s);
    cyc(2);
    check($sformatf("level@%0d", s), int'(level), lv);
    check($sformatf("period@%0d", s), int'(gravity_period), per);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; frame_tick = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_rotate = 1'b0;
    btn_drop = 1'b0; btn_start = 1'b0;
    engine_busy = 1'b0; game_over = 1'b0; op_ready = 1'b1; score = 8'd0;
    cyc(3);
    check("reset_op_valid", int'(op_valid), 0);
    check("reset_op", int'(op), 0);
    check("reset_level", int'(level), 0);
    check("reset_period", int'(gravity_period), 48);
    reset = 1'b0;
    cyc(2);

    // Start, then gravity at level 0: op 5 exactly on tick 48.
    start_game();
    repeat (47) tick();
    check("no_fall_before_48", exp_q.size(), 0);
    exp_q.push_back(3'd5);
    tick();
    cyc(3);
    check("fall_on_48_drained", exp_q.size(), 0);

    // Soft drop.
    exp_q.push_back(3'd5);
    btn_drop = 1'b1;
    tick();
    btn_drop = 1'b0;
    cyc(3);

    // Level / period table including floor.
    chk_score(30, 3, 36);
    chk_score(95, 9, 12);
    chk_score(120, 12, 6);
    chk_score(200, 15, 6);
    chk_score(0, 0, 48);

    // Busy blocks arbitration; then priority under backpressure.
    engine_busy = 1'b1;
    op_ready    = 1'b0;
    btn_rotate = 1'b1; cyc(1); btn_rotate = 1'b0; cyc(1);
    btn_left   = 1'b1; cyc(1); btn_left   = 1'b0; cyc(1);
    btn_drop = 1'b1; tick(); btn_drop = 1'b0;
    cyc(4);
    check("busy_no_valid", int'(op_valid), 0);
    exp_q.push_back(3'd5);
    exp_q.push_back(3'd3);
    exp_q.push_back(3'd1);
    engine_busy = 1'b0;
    cyc(1);
    check("prio_valid", int'(op_valid), 1);
    check("prio_first_op", int'(op), 5);
    cyc(5);
    op_ready = 1'b1;
    cyc(10);
    check("prio_drained", exp_q.size(), 0);

    // Left and right on the same edge cancel; a held key fires once.
    btn_left = 1'b1; btn_right = 1'b1; cyc(1);
    btn_left = 1'b0; btn_right = 1'b0; cyc(5);
    exp_q.push_back(3'd1);
    btn_left = 1'b1; cyc(8); btn_left = 1'b0; cyc(3);
    check("held_left_once", exp_q.size(), 0);

    // game_over during ISSUE: transfer completes, then OVER ignores input.
    op_ready = 1'b0;
    exp_q.push_back(3'd3);
    btn_rotate = 1'b1; cyc(1); btn_rotate = 1'b0; cyc(2);
    check("go_issue_valid", int'(op_valid), 1);
    game_over = 1'b1;
    cyc(2);
    op_ready = 1'b1;
    cyc(2);
    btn_drop = 1'b1;
    repeat (60) tick();
    btn_drop = 1'b0;
    btn_left = 1'b1; cyc(1); btn_left = 1'b0; cyc(2);
    check("over_silent", int'(op_valid), 0);
    game_over = 1'b0;
    cyc(2);
    btn_rotate = 1'b1; cyc(1); btn_rotate = 1'b0; cyc(3);
    check("idle_ignores_rotate", int'(op_valid), 0);

    // Restart clears gravity counter: fall again on the 48th tick.
    start_game();
    repeat (47) tick();
    exp_q.push_back(3'd5);
    tick();
    cyc(3);
    check("restart_fall_drained", exp_q.size(), 0);

    // Reset while an op is pending: op lost, key held through reset is dead.
    score = 8'd200;
    cyc(2);
    op_ready = 1'b0;
    btn_rotate = 1'b1; cyc(1); btn_rotate = 1'b0; cyc(2);
    check("pre_reset_valid", int'(op_valid), 1);
    btn_left = 1'b1;
    reset = 1'b1;
    cyc(1);
    check("reset_mid_valid", int'(op_valid), 0);
    check("reset_mid_period", int'(gravity_period), 48);
    reset = 1'b0;
    score = 8'd0;
    op_ready = 1'b1;
    cyc(4);
    start_game();
    cyc(6);
    btn_left = 1'b0;
    cyc(3);
    check("final_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
